// File: rtl/vio.sv
// Virtual I/O debug block: samples a probe bus, keeps sticky edge flags and drives a host-writable output.
// Optional macro VIO_ACTIVITY_EN builds the RISE/FALL read-clear flag registers.
module vio #(
    parameter int          IN_WIDTH  = 32,
    parameter int          OUT_WIDTH = 32,
    parameter logic [31:0] OUT_INIT  = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE  = 32'h5649_4F01
) (
    input  logic                 w_clk,
    input  logic                 w_rst,
    input  logic [IN_WIDTH-1:0]  probe_in0,
    output logic [OUT_WIDTH-1:0] probe_out0,
    input  logic [2:0]           host_addr,
    input  logic                 host_rd,
    input  logic                 host_wr,
    input  logic [31:0]          host_wdata,
    output logic [31:0]          host_rdata,
    output logic                 host_rvalid
);

    logic [IN_WIDTH-1:0]  r_probe_q;
    logic [IN_WIDTH-1:0]  r_probe_p;
    logic [IN_WIDTH-1:0]  r_snap;
    logic [OUT_WIDTH-1:0] r_out;
    logic                 r_freeze;
    logic [31:0]          r_cycles;
    logic [31:0]          r_rdata;
    logic                 r_rvalid;
    logic [31:0]          w_rd_mux;
    logic                 w_wr_out;
    logic                 w_wr_ctrl;

    assign w_wr_out   = host_wr && (host_addr == 3'd3);
    assign w_wr_ctrl  = host_wr && (host_addr == 3'd4);
    assign probe_out0 = r_out;
    assign host_rdata = r_rdata;
    assign host_rvalid = r_rvalid;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_probe_q <= '0;
            r_probe_p <= '0;
            r_snap    <= '0;
            r_out     <= OUT_INIT[OUT_WIDTH-1:0];
            r_freeze  <= 1'b0;
            r_cycles  <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            r_probe_q <= probe_in0;
            r_probe_p <= r_probe_q;
            if (!r_freeze)
                r_snap <= r_probe_q;
            if (w_wr_out)
                r_out <= host_wdata[OUT_WIDTH-1:0];
            if (w_wr_ctrl)
                r_freeze <= host_wdata[0];
            r_cycles <= r_cycles + 32'd1;
            r_rvalid <= host_rd;
            // Mux reads pre-edge state, so a same-cycle write is not visible yet.
            if (host_rd)
                r_rdata <= w_rd_mux;
        end
    end

`ifdef VIO_ACTIVITY_EN
    logic [IN_WIDTH-1:0] r_rise;
    logic [IN_WIDTH-1:0] r_fall;
    logic [IN_WIDTH-1:0] w_rise_det;
    logic [IN_WIDTH-1:0] w_fall_det;
    logic                w_clr_rise;
    logic                w_clr_fall;

    assign w_rise_det = r_probe_q & ~r_probe_p;
    assign w_fall_det = ~r_probe_q & r_probe_p;
    assign w_clr_rise = host_rd && (host_addr == 3'd1);
    assign w_clr_fall = host_rd && (host_addr == 3'd2);

    // Newly detected edges are OR-ed after the clear so set wins.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= (r_rise & {IN_WIDTH{~w_clr_rise}}) | w_rise_det;
            r_fall <= (r_fall & {IN_WIDTH{~w_clr_fall}}) | w_fall_det;
        end
    end
`else
    logic w_unused_probe_p;
    assign w_unused_probe_p = ^r_probe_p;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (host_addr)
            3'd0: w_rd_mux[IN_WIDTH-1:0]  = r_snap;
`ifdef VIO_ACTIVITY_EN
            3'd1: w_rd_mux[IN_WIDTH-1:0]  = r_rise;
            3'd2: w_rd_mux[IN_WIDTH-1:0]  = r_fall;
`endif
            3'd3: w_rd_mux[OUT_WIDTH-1:0] = r_out;
            3'd4: w_rd_mux[0]             = r_freeze;
            3'd5: w_rd_mux                = r_cycles;
            3'd6: w_rd_mux                = ID_VALUE;
            default: w_rd_mux             = '0;
        endcase
    end

endmodule

// File: tb/tb_vio.sv
// Directed self-checking bench for vio; flag expectations follow VIO_ACTIVITY_EN.
module tb_vio;

    logic        w_clk = 1'b0;
    logic        w_rst = 1'b1;
    logic [31:0] probe_in0 = '0;
    logic [31:0] probe_out0;
    logic [2:0]  host_addr = '0;
    logic        host_rd = 1'b0;
    logic        host_wr = 1'b0;
    logic [31:0] host_wdata = '0;
    logic [31:0] host_rdata;
    logic        host_rvalid;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] tb_cyc;
    logic [31:0] d;

`ifdef VIO_ACTIVITY_EN
    localparam logic [31:0] FLAG1 = 32'h1;
`else
    localparam logic [31:0] FLAG1 = 32'h0;
`endif

    vio #(
        .IN_WIDTH(32), .OUT_WIDTH(32), .OUT_INIT(32'h0000_00A5), .ID_VALUE(32'h5649_4F01)
    ) dut (
        .w_clk(w_clk), .w_rst(w_rst), .probe_in0(probe_in0), .probe_out0(probe_out0),
        .host_addr(host_addr), .host_rd(host_rd), .host_wr(host_wr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid)
    );

    always #5 w_clk = ~w_clk;

    // Reference cycle count: non-reset edges seen so far.
    always @(posedge w_clk) tb_cyc <= w_rst ? 32'd0 : tb_cyc + 32'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] rd);
        @(negedge w_clk);
        host_addr = a; host_rd = 1'b1;
        @(posedge w_clk); #1;
        chk("rvalid_on_read", {31'd0, host_rvalid}, 32'd1);
        rd = host_rdata;
        host_rd = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] wd);
        @(negedge w_clk);
        host_addr = a; host_wr = 1'b1; host_wdata = wd;
        @(posedge w_clk); #1;
        host_wr = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge w_clk);
        #1;
        chk("rst_out", probe_out0, 32'h0000_00A5);
        chk("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        chk("rst_rdata", host_rdata, 32'd0);
        @(negedge w_clk); w_rst = 1'b0;
        @(posedge w_clk);
        do_read(3'd5, d); chk("cycles_after_rst", d, 32'd1);

        // Snapshot path
        @(negedge w_clk); probe_in0 = 32'h1234_5678;
        repeat (3) @(posedge w_clk);
        do_read(3'd0, d); chk("snap", d, 32'h1234_5678);
        @(posedge w_clk); #1;
        chk("rvalid_one_cycle", {31'd0, host_rvalid}, 32'd0);
        chk("rdata_hold", host_rdata, 32'h1234_5678);

        // Freeze holds IN_SNAP
        do_write(3'd4, 32'd1);
        do_read(3'd4, d); chk("ctrl_rd", d, 32'd1);
        @(negedge w_clk); probe_in0 = 32'hDEAD_BEEF;
        repeat (3) @(posedge w_clk);
        do_read(3'd0, d); chk("snap_frozen", d, 32'h1234_5678);
        do_write(3'd4, 32'hFFFF_FFFE);
        do_read(3'd4, d); chk("ctrl_clr", d, 32'd0);
        repeat (2) @(posedge w_clk);
        do_read(3'd0, d); chk("snap_unfrozen", d, 32'hDEAD_BEEF);

        // Activity flags on bit0
        @(negedge w_clk); probe_in0 = 32'h0;
        repeat (3) @(posedge w_clk);
        do_read(3'd1, d);
        do_read(3'd2, d);
        do_read(3'd1, d); chk("rise_cleared", d, 32'd0);
        @(negedge w_clk); probe_in0 = 32'h1;
        repeat (3) @(posedge w_clk);
        @(negedge w_clk); probe_in0 = 32'h0;
        repeat (3) @(posedge w_clk);
        do_read(3'd1, d); chk("rise_set", d, FLAG1);
        do_read(3'd1, d); chk("rise_rdclr", d, 32'd0);
        do_read(3'd2, d); chk("fall_set", d, FLAG1);
        do_read(3'd2, d); chk("fall_rdclr", d, 32'd0);
        @(negedge w_clk); probe_in0 = 32'h1;
        @(posedge w_clk);
        do_read(3'd1, d); chk("rise_coinc_rd", d, 32'd0);
        do_read(3'd1, d); chk("rise_set_wins", d, FLAG1);

        // Same-cycle rd+wr to OUT
        @(negedge w_clk);
        host_addr = 3'd3; host_rd = 1'b1; host_wr = 1'b1; host_wdata = 32'h0000_0F0F;
        @(posedge w_clk); #1;
        chk("rdwr_rdata", host_rdata, 32'h0000_00A5);
        chk("rdwr_rvalid", {31'd0, host_rvalid}, 32'd1);
        chk("rdwr_out", probe_out0, 32'h0000_0F0F);
        host_rd = 1'b0; host_wr = 1'b0;
        do_read(3'd3, d); chk("out_rd", d, 32'h0000_0F0F);

        // Read-only and unused addresses
        do_write(3'd5, 32'd0);
        do_read(3'd5, d); chk("cycles_ro", d, tb_cyc - 32'd1);
        do_write(3'd6, 32'd0);
        do_read(3'd6, d); chk("id", d, 32'h5649_4F01);
        do_write(3'd7, 32'hFFFF_FFFF);
        do_read(3'd7, d); chk("addr7", d, 32'd0);

        // Reset mid-operation discards a concurrent write
        @(negedge w_clk);
        w_rst = 1'b1; host_addr = 3'd3; host_wr = 1'b1; host_rd = 1'b1; host_wdata = 32'h1234;
        @(posedge w_clk); #1;
        chk("midrst_out", probe_out0, 32'h0000_00A5);
        chk("midrst_rvalid", {31'd0, host_rvalid}, 32'd0);
        chk("midrst_rdata", host_rdata, 32'd0);
        host_wr = 1'b0; host_rd = 1'b0;
        @(negedge w_clk); w_rst = 1'b0;
        @(posedge w_clk);
        @(posedge w_clk);
        do_read(3'd1, d); chk("first_sample_rise", d, FLAG1);
        do_read(3'd4, d); chk("midrst_ctrl", d, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
